// File: rtl/banqi_board_store_if.sv
// Host-side bundle of the Banqi board store: control strobes, write/reveal/read
// ports, status flags and the flat board bus for the VGA drawer.
interface banqi_board_store_if #(
   parameter int unsigned SQUARES = 32,
   parameter int unsigned ADDR_W  = 5,
   parameter int unsigned PIECE_W = 5
);
   logic                         init_req;
   logic                         seed_load;
   logic [15:0]                  seed_in;
   logic                         wr_en;
   logic [ADDR_W-1:0]            wr_addr;
   logic [PIECE_W-1:0]           wr_piece;
   logic                         reveal_en;
   logic [ADDR_W-1:0]            reveal_addr;
   logic [ADDR_W-1:0]            rd_addr;
   logic [PIECE_W-1:0]           rd_piece;
   logic [SQUARES*PIECE_W-1:0]   board_flat;
   logic                         busy;
   logic                         init_done;

   modport master (
      output init_req, seed_load, seed_in, wr_en, wr_addr, wr_piece,
             reveal_en, reveal_addr, rd_addr,
      input  rd_piece, board_flat, busy, init_done
   );

   modport slave (
      input  init_req, seed_load, seed_in, wr_en, wr_addr, wr_piece,
             reveal_en, reveal_addr, rd_addr,
      output rd_piece, board_flat, busy, init_done
   );
endinterface

// File: rtl/banqi_board_store.sv
// Banqi board memory: canonical piece fill, LFSR-driven Fisher-Yates shuffle,
// idle-time write/reveal port, registered read port and a flat board bus.
module banqi_board_store #(
   parameter int unsigned SQUARES   = 32,
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned PIECE_W   = 5,
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   parameter int unsigned MAX_RETRY = 15
) (
   input logic                CLK,
   input logic                RESET,
   banqi_board_store_if.slave bus
);
   localparam int unsigned IDX_W   = (SQUARES > 1) ? $clog2(SQUARES) : 1;
   localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam int unsigned AW1     = ADDR_W + 1;
   localparam logic [15:0] TAPS    = 16'hB400;

   typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_SHUFFLE, ST_DONE} state_e;

   state_e               state_q;
   logic [ADDR_W-1:0]    idx_q;
   logic [ADDR_W-1:0]    i_q;
   logic [RETRY_W-1:0]   retry_q;
   logic [15:0]          lfsr_q;
   logic [15:0]          lfsr_d;
   logic [PIECE_W-1:0]   rd_piece_q;
   logic                 busy_q;
   logic                 init_done_q;
   logic [PIECE_W-1:0]   board_q [SQUARES];

   logic [ADDR_W-1:0]    j;
   logic                 wr_hit, rev_hit, swap, advance, last;

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < AW1'(SQUARES));
   endfunction

   // Starting layout: per 16-square half, one king, pairs of 6..2, five pawns.
   function automatic logic [PIECE_W-1:0] canonical(input logic [ADDR_W-1:0] idx);
      int unsigned k;
      logic [2:0]  kind;
      logic        color;
      k     = 32'(idx) % 16;
      color = (32'(idx) < SQUARES / 2);
      if (k == 0)       kind = 3'd7;
      else if (k <= 2)  kind = 3'd6;
      else if (k <= 4)  kind = 3'd5;
      else if (k <= 6)  kind = 3'd4;
      else if (k <= 8)  kind = 3'd3;
      else if (k <= 10) kind = 3'd2;
      else              kind = 3'd1;
      return PIECE_W'({color, kind, 1'b0});
   endfunction

   // Galois LFSR step; an explicit seed load overrides stepping.
   always_comb begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);
      if (bus.seed_load) lfsr_d = (bus.seed_in == 16'h0000) ? LFSR_SEED : bus.seed_in;
   end

   assign j       = lfsr_q[ADDR_W-1:0];
   assign wr_hit  = (state_q == ST_IDLE) && bus.wr_en && in_range(bus.wr_addr);
   assign rev_hit = (state_q == ST_IDLE) && bus.reveal_en && in_range(bus.reveal_addr)
                    && !(wr_hit && (bus.reveal_addr == bus.wr_addr));
   assign swap    = (j <= i_q);
   assign advance = swap || (retry_q == RETRY_W'(MAX_RETRY));
   assign last    = advance && (i_q == ADDR_W'(1));

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         i_q         <= '0;
         retry_q     <= '0;
         lfsr_q      <= LFSR_SEED;
         rd_piece_q  <= '0;
         busy_q      <= 1'b0;
         init_done_q <= 1'b0;
         for (int k = 0; k < SQUARES; k++) board_q[k] <= '0;
      end else begin
         lfsr_q      <= lfsr_d;
         rd_piece_q  <= in_range(bus.rd_addr) ? board_q[IDX_W'(bus.rd_addr)] : '0;
         init_done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (wr_hit)  board_q[IDX_W'(bus.wr_addr)] <= bus.wr_piece;
               if (rev_hit) board_q[IDX_W'(bus.reveal_addr)] <=
                               board_q[IDX_W'(bus.reveal_addr)] | PIECE_W'(1);
               if (bus.init_req) begin
                  state_q <= ST_FILL;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            ST_FILL: begin
               board_q[IDX_W'(idx_q)] <= canonical(idx_q);
               idx_q <= idx_q + ADDR_W'(1);
               if (idx_q == ADDR_W'(SQUARES - 1)) begin
                  state_q <= ST_SHUFFLE;
                  i_q     <= ADDR_W'(SQUARES - 1);
                  retry_q <= '0;
               end
            end
            ST_SHUFFLE: begin
               // j beyond i is rejected; after MAX_RETRY rejections i is forced down.
               if (swap) begin
                  board_q[IDX_W'(i_q)] <= board_q[IDX_W'(j)];
                  board_q[IDX_W'(j)]   <= board_q[IDX_W'(i_q)];
               end
               if (advance) begin
                  i_q     <= i_q - ADDR_W'(1);
                  retry_q <= '0;
               end else begin
                  retry_q <= retry_q + RETRY_W'(1);
               end
               if (last) begin
                  state_q     <= ST_DONE;
                  busy_q      <= 1'b0;
                  init_done_q <= 1'b1;
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   for (genvar k = 0; k < SQUARES; k++) begin : g_flat
      assign bus.board_flat[k*PIECE_W +: PIECE_W] = board_q[k];
   end

   assign bus.rd_piece  = rd_piece_q;
   assign bus.busy      = busy_q;
   assign bus.init_done = init_done_q;
endmodule

// File: tb/tb_banqi_board_store.sv
// Randomised self-checking bench for banqi_board_store against a reference
// model of the fill/shuffle rules and the idle host port.
module tb_banqi_board_store;
   localparam int unsigned S  = 32;
   localparam int unsigned AW = 5;
   localparam int unsigned PW = 5;

   logic CLK = 1'b0;
   logic RESET = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   logic [PW-1:0] ref_board [S];
   logic [PW-1:0] saved [S];

   banqi_board_store_if #(.SQUARES(S), .ADDR_W(AW), .PIECE_W(PW)) bus ();
   banqi_board_store_if #(.SQUARES(S), .ADDR_W(6),  .PIECE_W(PW)) bus2 ();

   banqi_board_store #(.SQUARES(S), .ADDR_W(AW), .PIECE_W(PW),
                       .LFSR_SEED(16'hACE1), .MAX_RETRY(15))
      dut (.CLK(CLK), .RESET(RESET), .bus(bus.slave));

   banqi_board_store #(.SQUARES(S), .ADDR_W(6), .PIECE_W(PW),
                       .LFSR_SEED(16'hACE1), .MAX_RETRY(15))
      dut6 (.CLK(CLK), .RESET(RESET), .bus(bus2.slave));

   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [PW-1:0] sq(input int k);
      return bus.board_flat[k*PW +: PW];
   endfunction

   function automatic logic [PW-1:0] sq2(input int k);
      return bus2.board_flat[k*PW +: PW];
   endfunction

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
   endfunction

   task automatic idle_inputs();
      bus.init_req = 0; bus.seed_load = 0; bus.seed_in = '0;
      bus.wr_en = 0; bus.wr_addr = '0; bus.wr_piece = '0;
      bus.reveal_en = 0; bus.reveal_addr = '0; bus.rd_addr = '0;
   endtask

   // Expected post-init board for a seed loaded one cycle before init_req.
   task automatic model_init(input logic [15:0] seed, output int n);
      int kt [16];
      int i, jj, r;
      logic [15:0] L;
      logic [PW-1:0] t;
      kt = '{7, 6, 6, 5, 5, 4, 4, 3, 3, 2, 2, 1, 1, 1, 1, 1};
      for (int k = 0; k < S; k++)
         ref_board[k] = {(k < S / 2) ? 1'b1 : 1'b0, 3'(kt[k % 16]), 1'b0};
      L = (seed == 16'h0000) ? 16'hACE1 : seed;
      repeat (S + 1) L = lfsr_step(L);
      i = S - 1; r = 0; n = 0;
      while (i > 0) begin
         jj = 32'(L[AW-1:0]);
         if (jj <= i) begin
            t = ref_board[i]; ref_board[i] = ref_board[jj]; ref_board[jj] = t;
            i--; r = 0;
         end else if (r == 15) begin
            i--; r = 0;
         end else begin
            r++;
         end
         L = lfsr_step(L);
         n++;
      end
   endtask

   task automatic check_board(input string tag);
      for (int k = 0; k < S; k++)
         check($sformatf("%s_sq%0d", tag, k), sq(k), ref_board[k]);
   endtask

   task automatic check_multiset(input string tag);
      int cnt [2][8];
      int st;
      logic [PW-1:0] p;
      st = 0;
      for (int c = 0; c < 2; c++) for (int kd = 0; kd < 8; kd++) cnt[c][kd] = 0;
      for (int k = 0; k < S; k++) begin
         p = sq(k);
         cnt[p[4]][p[3:1]]++;
         st += int'(p[0]);
      end
      for (int c = 0; c < 2; c++)
         for (int kd = 1; kd < 8; kd++)
            check($sformatf("%s_c%0d_k%0d", tag, c, kd), cnt[c][kd],
                  (kd == 7) ? 1 : (kd == 1) ? 5 : 2);
      check({tag, "_state_bits"}, st, 0);
   endtask

   // Seed + init, with host writes/reveals/init_req injected while busy and in DONE.
   task automatic do_init(input logic [15:0] seed, input string tag);
      int n, busy_cnt;
      bit seen;
      model_init(seed, n);
      @(posedge CLK); #1; bus.seed_load = 1; bus.seed_in = seed;
      @(posedge CLK); #1; bus.seed_load = 0; bus.init_req = 1;
      @(posedge CLK); #1; bus.init_req = 0;
      busy_cnt = 0; seen = 0;
      for (int g = 0; g < 2000 && !seen; g++) begin
         if (bus.init_done) seen = 1;
         else begin
            if (bus.busy) busy_cnt++;
            bus.wr_en = (busy_cnt == 10 || busy_cnt == S + 8);
            bus.wr_addr = AW'(3); bus.wr_piece = 5'b01000;
            bus.reveal_en = (busy_cnt == S + 9); bus.reveal_addr = AW'(4);
            bus.init_req = (busy_cnt == S + 12);
            @(posedge CLK); #1;
         end
      end
      check({tag, "_done_seen"}, seen, 1);
      check({tag, "_busy_cycles"}, busy_cnt, S + n);
      check({tag, "_busy_at_done"}, bus.busy, 0);
      bus.wr_en = 1; bus.wr_addr = AW'(3); bus.wr_piece = 5'b01000;
      bus.reveal_en = 1; bus.reveal_addr = AW'(5); bus.init_req = 1;
      @(posedge CLK); #1;
      idle_inputs();
      check({tag, "_done_single"}, bus.init_done, 0);
      @(posedge CLK); #1;
      check({tag, "_no_restart"}, bus.busy, 0);
      check_board(tag);
      check_multiset(tag);
   endtask

   task automatic idle_op(input bit we, input int wa, input logic [PW-1:0] wp,
                          input bit re, input int ra, input int rd, input string tag);
      logic [PW-1:0] exp_rd;
      bus.wr_en = we; bus.wr_addr = AW'(wa); bus.wr_piece = wp;
      bus.reveal_en = re; bus.reveal_addr = AW'(ra); bus.rd_addr = AW'(rd);
      exp_rd = ref_board[rd];
      if (re && !(we && wa == ra)) ref_board[ra][0] = 1'b1;
      if (we) ref_board[wa] = wp;
      @(posedge CLK); #1;
      bus.wr_en = 0; bus.reveal_en = 0;
      check({tag, "_rd"}, bus.rd_piece, exp_rd);
      check({tag, "_wsq"}, sq(wa), ref_board[wa]);
      check({tag, "_rsq"}, sq(ra), ref_board[ra]);
   endtask

   initial begin
      bit bad;
      idle_inputs();
      bus2.init_req = 0; bus2.seed_load = 0; bus2.seed_in = '0;
      bus2.wr_en = 0; bus2.wr_addr = '0; bus2.wr_piece = '0;
      bus2.reveal_en = 0; bus2.reveal_addr = '0; bus2.rd_addr = '0;
      for (int k = 0; k < S; k++) ref_board[k] = '0;

      // Reset state.
      repeat (3) @(posedge CLK);
      #1; RESET = 1;
      check_board("reset");
      check("reset_busy", bus.busy, 0);
      check("reset_rd", bus.rd_piece, 0);
      bad = 0;
      repeat (5) begin @(posedge CLK); #1; if (bus.init_done || bus.busy) bad = 1; end
      check("reset_quiet", bad, 0);

      // Wide-address instance: addresses beyond the board are ignored / read as 0.
      bus2.wr_en = 1; bus2.wr_addr = 6'd8; bus2.wr_piece = 5'b10110;
      @(posedge CLK); #1;
      bus2.wr_addr = 6'd40; bus2.wr_piece = 5'b11111;
      bus2.reveal_en = 1; bus2.reveal_addr = 6'd40; bus2.rd_addr = 6'd8;
      @(posedge CLK); #1;
      bus2.wr_en = 0; bus2.reveal_en = 0;
      check("w6_rd8", bus2.rd_piece, 5'b10110);
      bus2.rd_addr = 6'd40;
      @(posedge CLK); #1;
      check("w6_rd40", bus2.rd_piece, 0);
      for (int k = 0; k < S; k++)
         check($sformatf("w6_sq%0d", k), sq2(k), (k == 8) ? 5'b10110 : 5'b00000);

      // Directed idle host accesses.
      idle_op(0, 0, '0, 1, 7, 7, "reveal7");
      idle_op(1, 7, 5'b00000, 1, 7, 7, "wr_rev7");
      idle_op(1, 7, 5'b10110, 0, 0, 7, "wr7");
      idle_op(0, 0, '0, 0, 0, 7, "rd7");

      // Init with seed 1, then random idle traffic.
      do_init(16'h0001, "init1");
      for (int k = 0; k < S; k++) saved[k] = ref_board[k];
      for (int c = 0; c < 150; c++)
         idle_op(($urandom_range(0, 2) == 0), $urandom_range(0, S - 1), PW'($urandom),
                 ($urandom_range(0, 2) == 0), $urandom_range(0, S - 1),
                 $urandom_range(0, S - 1), "rand");

      // Determinism and zero-seed substitution.
      do_init(16'h0001, "init1b");
      for (int k = 0; k < S; k++) check($sformatf("det1_sq%0d", k), sq(k), saved[k]);
      do_init(16'h0000, "init0");
      for (int k = 0; k < S; k++) saved[k] = sq(k);
      do_init(16'hACE1, "initace");
      for (int k = 0; k < S; k++) check($sformatf("det0_sq%0d", k), sq(k), saved[k]);
      do_init(16'(32'h5A5A ^ $urandom_range(1, 16'hFFFF)), "initrnd");

      // Reset ten cycles into the shuffle.
      @(posedge CLK); #1; bus.seed_load = 1; bus.seed_in = 16'h0001;
      @(posedge CLK); #1; bus.seed_load = 0; bus.init_req = 1;
      @(posedge CLK); #1; bus.init_req = 0;
      repeat (S + 10) @(posedge CLK);
      #2;
      check("midrst_busy_before", bus.busy, 1);
      RESET = 0;
      #1;
      for (int k = 0; k < S; k++) ref_board[k] = '0;
      check("midrst_busy", bus.busy, 0);
      check("midrst_done", bus.init_done, 0);
      check("midrst_rd", bus.rd_piece, 0);
      check_board("midrst");
      @(posedge CLK); #1; RESET = 1;
      bad = 0;
      repeat (100) begin @(posedge CLK); #1; if (bus.init_done || bus.busy) bad = 1; end
      check("midrst_idle", bad, 0);
      idle_op(1, 9, 5'b11010, 1, 2, 9, "post_rst");
      idle_op(0, 0, '0, 0, 0, 9, "post_rst_rd");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/banqi_board_store.md
Name: banqi_board_store

Overview:
Parametrised board memory for the Banqi game, replacing the flat per-square register array at top level.
- Holds SQUARES pieces, PIECE_W bits each, encoded {color, kind[2:0], state}.
- Rebuilds the canonical piece set on request, then shuffles it face-down with an LFSR-driven Fisher-Yates pass, so each game starts with a random hidden layout.
- Serves the game-logic write/reveal port, a registered read port and a flat bus for the VGA drawer.

Parameters:
SQUARES, 32, number of board squares; must be even, at least 2, and at most 2^ADDR_W.
ADDR_W, 5, square address width.
PIECE_W, 5, piece word width; fixed encoding {color, kind[2:0], state}.
LFSR_SEED, 16'hACE1, LFSR value after reset and the substitute for a zero seed.
MAX_RETRY, 15, consecutive shuffle rejections allowed before a forced no-op swap.

Ports:
CLK  in  1  system clock.
RESET  in  1  asynchronous, active-low reset.
init_req  in  1  one-cycle pulse: start fill + shuffle.
seed_load  in  1  load seed_in into the LFSR this cycle.
seed_in  in  16  LFSR seed; zero is replaced by LFSR_SEED.
wr_en  in  1  write wr_piece to wr_addr.
wr_addr  in  ADDR_W  write address.
wr_piece  in  PIECE_W  write data.
reveal_en  in  1  set the state bit (bit 0) of reveal_addr.
reveal_addr  in  ADDR_W  reveal address.
rd_addr  in  ADDR_W  read address.
rd_piece  out  PIECE_W  registered read data.
board_flat  out  SQUARES*PIECE_W  square k occupies bits [k*PIECE_W+PIECE_W-1 : k*PIECE_W]; driven combinationally from the store.
busy  out  1  high during FILL and SHUFFLE.
init_done  out  1  one-cycle pulse when the shuffle completes.

Behaviour:
Reset (RESET low, asynchronous):
- All squares 0 (PIECE_NONE).
- rd_piece=0, busy=0, init_done=0, LFSR=LFSR_SEED, FSM=IDLE.
- Reset mid-FILL or mid-SHUFFLE aborts immediately to these values.

LFSR:
- 16-bit Galois, taps mask 16'hB400, steps every cycle in every state.
- seed_load has priority over stepping.

FSM states: IDLE, FILL, SHUFFLE, DONE.
- IDLE: on init_req go to FILL with idx=0; busy rises the following cycle.
- FILL: each cycle write canonical(idx) to square idx, idx++. After idx=SQUARES-1, go to SHUFFLE with i=SQUARES-1 and retry=0. Duration is SQUARES cycles.
- canonical(idx):
  - k = idx mod 16.
  - kind: k=0 →7 (king); 1-2 →6; 3-4 →5; 5-6 →4; 7-8 →3; 9-10 →2; 11-15 →1 (pawn).
  - color = 1 (black) if idx < SQUARES/2, else 0.
  - state = 0 (covered).
- SHUFFLE, one step per cycle:
  - j = LFSR[ADDR_W-1:0].
  - If j≤i: swap squares i and j in the same cycle, i--, retry=0.
  - Else if retry==MAX_RETRY: no-op (j=i), i--, retry=0.
  - Else: retry++, i unchanged.
  - When i reaches 0, go to DONE.
- DONE: init_done=1 for one cycle, busy=0 in the same cycle, return to IDLE.
- The same seed loaded before init_req, with identical cycle timing, gives an identical board.

Host access:
- While busy=1 (including the DONE cycle), wr_en, reveal_en and init_req are ignored.
- While idle:
  - wr_en writes the full word.
  - reveal_en ORs 1 into bit 0 of reveal_addr.
  - Same cycle, same address: the wr_en data wins and the reveal is dropped.
  - Same cycle, different addresses: both take effect.
- Addresses ≥ SQUARES are ignored for wr_en and reveal_en; rd_piece returns 0 for them.
- rd_piece = board[rd_addr] registered with 1-cycle latency, read-before-write. A write to the same address is visible one cycle later.

Test Plan:
- Reset: release RESET after 3 cycles → board_flat all 0, busy=0, rd_piece=0, init_done never pulses.
- Init: seed_load with 16'h0001, then init_req. Required:
  - busy high ≥63 cycles (32 FILL + ≥31 SHUFFLE), then a single init_done pulse.
  - Each color has exactly 1 kind 7; 2 each of kinds 6, 5, 4, 3 and 2; 5 of kind 1.
  - Every state bit is 0.
- Determinism: repeat the init with seed 16'h0001 and identical timing → bit-identical board_flat. Seed 16'h0000 → same board as seed 16'hACE1.
- Writes during busy: wr_en to square 3 with 5'b01000 mid-SHUFFLE → ignored; the piece multiset is unchanged after init_done.
- Reveal/write/read:
  - Idle reveal_en on 7 → bit 0 of square 7 = 1.
  - Simultaneous wr_en(7, 5'b00000) and reveal_en(7) → square 7 = 0.
  - rd_addr=7 → rd_piece valid on the next edge.
  - rd_addr=40 with ADDR_W=6, SQUARES=32 → rd_piece=0.
- Reset mid-shuffle: drop RESET 10 cycles into SHUFFLE → all squares 0, busy=0 asynchronously, FSM in IDLE, no init_done.
